// File: rtl/key_repeat_ctrl.sv
// Key auto-repeat controller: one step on press, one after a hold delay, then one per repeat period.
// Optional feature: define KEY_REPEAT_ACCEL_EN to halve the repeat period once rep_cnt reaches 8.
module key_repeat_ctrl #(
  parameter int T_HOLD = 500,
  parameter int T_REP  = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce1ms,
  input  logic       Ux,
  output logic       step,
  output logic       held,
  output logic [7:0] rep_cnt,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    S_ARM    = 2'd0,
    S_IDLE   = 2'd1,
    S_HOLD   = 2'd2,
    S_REPEAT = 2'd3
  } state_t;

  localparam logic [9:0] HOLD_LAST = 10'(T_HOLD - 1);
  localparam logic [9:0] REP_LAST  = 10'(T_REP - 1);
`ifdef KEY_REPEAT_ACCEL_EN
  localparam int         T_FAST    = (T_REP / 2 < 1) ? 1 : T_REP / 2;
  localparam logic [9:0] FAST_LAST = 10'(T_FAST - 1);
`endif

  state_t      state_q, state_d;
  logic        ux_q;
  logic [9:0]  cnt_q, cnt_d;
  logic [7:0]  rep_cnt_q, rep_cnt_d;
  logic        step_q, step_d;
  logic        held_q, held_d;
  logic        rise;
  logic [9:0]  period_last;
  logic [7:0]  rep_inc;

  assign rise    = Ux & ~ux_q;
  assign rep_inc = (rep_cnt_q == 8'hFF) ? rep_cnt_q : rep_cnt_q + 8'd1;

`ifdef KEY_REPEAT_ACCEL_EN
  assign period_last = (rep_cnt_q >= 8'd8) ? FAST_LAST : REP_LAST;
`else
  assign period_last = REP_LAST;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rep_cnt_d = rep_cnt_q;
    step_d    = 1'b0;
    case (state_q)
      S_ARM: begin
        if (!Ux) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (rise) begin
          state_d   = S_HOLD;
          cnt_d     = 10'd0;
          rep_cnt_d = 8'd0;
          step_d    = 1'b1;
        end
      end
      S_HOLD: begin
        // Release is checked first so it beats a coincident terminal tick.
        if (!Ux) begin
          state_d = S_IDLE;
          cnt_d   = 10'd0;
        end else if (ce1ms) begin
          if (cnt_q == HOLD_LAST) begin
            state_d   = S_REPEAT;
            cnt_d     = 10'd0;
            step_d    = 1'b1;
            rep_cnt_d = rep_inc;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
      end
      S_REPEAT: begin
        if (!Ux) begin
          state_d = S_IDLE;
          cnt_d   = 10'd0;
        end else if (ce1ms) begin
          if (cnt_q == period_last) begin
            cnt_d     = 10'd0;
            step_d    = 1'b1;
            rep_cnt_d = rep_inc;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
      end
      default: begin
        state_d = S_ARM;
        cnt_d   = 10'd0;
      end
    endcase
    held_d = (state_d == S_HOLD) || (state_d == S_REPEAT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_ARM;
      ux_q      <= 1'b0;
      cnt_q     <= 10'd0;
      rep_cnt_q <= 8'd0;
      step_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ux_q      <= Ux;
      cnt_q     <= cnt_d;
      rep_cnt_q <= rep_cnt_d;
      step_q    <= step_d;
      held_q    <= held_d;
    end
  end

  assign step        = step_q;
  assign held        = held_q;
  assign rep_cnt     = rep_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_key_repeat_ctrl.sv
// Directed bench for key_repeat_ctrl with T_HOLD=5, T_REP=3 and a ce1ms tick every 10 clocks.
// Step timing is tracked as the number of ce1ms ticks elapsed since the press.
module tb_key_repeat_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce1ms;
  logic       Ux;
  logic       step;
  logic       held;
  logic [7:0] rep_cnt;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int tick_total = 0;
  int step_total = 0;
  logic prev_step = 1'b0;
  logic [31:0] exp_q[$];

`ifdef KEY_REPEAT_ACCEL_EN
  localparam bit ACCEL = 1'b1;
`else
  localparam bit ACCEL = 1'b0;
`endif

  key_repeat_ctrl #(.T_HOLD(5), .T_REP(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .ce1ms       (ce1ms),
    .Ux          (Ux),
    .step        (step),
    .held        (held),
    .rep_cnt     (rep_cnt),
    .dbg_state_o (dbg_state)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One clock: sample outputs just after the edge, then schedule ce1ms for the next edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (ce1ms) tick_total++;
    if (step) step_total++;
    if (step && prev_step) check("step_double", 32'd1, 32'd0);
    prev_step = step;
    cyc++;
    ce1ms = (cyc % 10 == 0);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Leaves the bench so the next edge is the one right after a tick edge.
  task automatic align();
    for (int i = 0; i < 12 && !ce1ms; i++) cycle();
    cycle();
  endtask

  task automatic press_and_check(input string tag);
    Ux = 1'b1;
    cycle();
    check({tag, "_step"}, step, 1);
    check({tag, "_held"}, held, 1);
    check({tag, "_rep0"}, rep_cnt, 0);
  endtask

  initial begin
    int base;
    int s0;
    int nrep;
    int t;
    logic [31:0] e;

    rst = 1'b1; Ux = 1'b0; ce1ms = 1'b0;
    cycles(2);
    check("rst_step", step, 0);
    check("rst_held", held, 0);
    check("rst_rep", rep_cnt, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    cycles(3);
    check("idle_state", dbg_state, 1);

    // Single press: step one clock after the edge, exactly one clock wide.
    align();
    press_and_check("press");
    cycle();
    check("press_step_off", step, 0);
    check("press_held_stay", held, 1);
    Ux = 1'b0;
    cycles(3);

    // Long hold: first repeat 5 ticks after press, then every 3 (or 1 after 8 repeats with accel).
    nrep = 0; t = 5;
    while (t <= 40) begin
      exp_q.push_back(32'(t));
      nrep++;
      t += (ACCEL && nrep >= 8) ? 1 : 3;
    end
    align();
    press_and_check("hold");
    base = tick_total;
    nrep = 0;
    for (int i = 0; i < 399; i++) begin
      cycle();
      if (step) begin
        nrep++;
        if (exp_q.size() == 0) check("extra_step", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("rep_tick", 32'(tick_total - base), e);
        end
        check("rep_cnt_step", rep_cnt, 32'(nrep));
      end
    end
    check("rep_missing", 32'(exp_q.size()), 0);
    check("rep_total", rep_cnt, ACCEL ? 32'd22 : 32'd12);
    Ux = 1'b0;
    cycle();
    check("rel_held", held, 0);
    check("rel_rep_hold", rep_cnt, ACCEL ? 32'd22 : 32'd12);
    cycles(3);

    // Release after 3 ticks in HOLD.
    align();
    press_and_check("short");
    s0 = step_total;
    cycles(29);
    check("short_steps", 32'(step_total - s0), 0);
    Ux = 1'b0;
    cycle();
    check("short_held", held, 0);
    check("short_step", step, 0);
    check("short_rep", rep_cnt, 0);
    s0 = step_total;
    cycles(60);
    check("short_after", 32'(step_total - s0), 0);

    // Release coincident with the terminal HOLD tick.
    align();
    press_and_check("race");
    cycles(48);
    Ux = 1'b0;
    check("race_tick_pending", ce1ms, 1);
    cycle();
    check("race_step", step, 0);
    check("race_held", held, 0);
    check("race_rep", rep_cnt, 0);
    cycles(3);

    // Key held through reset is ignored until released.
    rst = 1'b1; Ux = 1'b1;
    cycles(2);
    rst = 1'b0;
    s0 = step_total;
    cycles(100);
    check("arm_steps", 32'(step_total - s0), 0);
    check("arm_held", held, 0);
    check("arm_state", dbg_state, 0);
    Ux = 1'b0;
    cycle();
    press_and_check("arm_repress");
    Ux = 1'b0;
    cycles(3);

    // Reset mid-REPEAT aborts at once.
    align();
    press_and_check("abort");
    cycles(60);
    check("abort_in_rep", dbg_state, 3);
    rst = 1'b1;
    cycle();
    check("abort_step", step, 0);
    check("abort_held", held, 0);
    check("abort_rep", rep_cnt, 0);
    rst = 1'b0;
    cycle();
    check("abort_step2", step, 0);
    check("abort_held2", held, 0);
    Ux = 1'b0;
    cycles(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_repeat_ctrl.md
KEY_REPEAT_CTRL -- requirements
Module: key_repeat_ctrl

Interface
REQ-001 SHALL have parameter T_HOLD, default 500, meaning hold delay in ce1ms ticks before auto-repeat starts (range 2..1023).
REQ-002 SHALL have parameter T_REP, default 100, meaning auto-repeat period in ce1ms ticks (range 2..1023).
REQ-003 SHALL have port clk  input  1  system clock, 50 MHz; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ce1ms  input  1  one-clk-wide 1 ms tick from the tick generator.
REQ-006 SHALL have port Ux  input  1  debounced key level; 1 = pressed.
REQ-007 SHALL have port step  output  1  one-clk pulse, one per counter increment request.
REQ-008 SHALL have port held  output  1  high while in HOLD or REPEAT.
REQ-009 SHALL have port rep_cnt  output  8  repeat pulses issued in current press, saturating at 255.

Function
REQ-010 SHALL implement FSM states ARM, IDLE, HOLD, REPEAT, all registered.
REQ-011 SHALL sample Ux into register Ux_q each clk; rising edge = Ux & ~Ux_q; falling = ~Ux.
REQ-012 ARM: wait for Ux=0, then go to IDLE; a key held through reset yields no step until released.
REQ-013 IDLE: on rising edge of Ux, go to HOLD, clear 10-bit ms counter, clear rep_cnt, assert step on the next clk (latency 1 clk from edge).
REQ-014 HOLD: increment ms counter on each ce1ms; when counter reaches T_HOLD-1 with ce1ms high, go to REPEAT, clear counter, assert step next clk, rep_cnt +1.
REQ-015 REPEAT: increment counter on each ce1ms; when counter reaches period-1 with ce1ms high, clear counter, assert step next clk, rep_cnt +1 (saturating).
REQ-016 HOLD or REPEAT with Ux=0: go to IDLE next clk, no step, counter cleared; rep_cnt holds its value until next press.
REQ-017 Ux=0 and terminal-count ce1ms in the same clk: release wins, no step.
REQ-018 step SHALL never be high on two consecutive clks; ce1ms held high does not advance the counter more than once per ce1ms pulse edge—counter advances once per clk with ce1ms=1 (caller guarantees 1-clk ce1ms).
REQ-019 held SHALL be registered, equal to (state==HOLD or state==REPEAT).
REQ-020 Unreachable state encodings SHALL recover to ARM on next clk.

Reset
REQ-021 rst=1 on a clk edge: state=ARM, step=0, held=0, rep_cnt=0, counter=0, Ux_q=0.
REQ-022 rst asserted mid-press SHALL abort immediately; no step issued in the reset cycle or the cycle after.
REQ-023 rst SHALL take priority over every other input.

Configuration
REQ-024 Macro KEY_REPEAT_ACCEL_EN defined: in REPEAT, once rep_cnt >= 8 the period SHALL be T_REP/2 (integer, minimum 1).
REQ-025 Macro KEY_REPEAT_ACCEL_EN undefined: period SHALL always be T_REP; no acceleration logic synthesized.

Verification (bench: T_HOLD=5, T_REP=3, ce1ms every 10 clk)
REQ-026 Ux 0->1 in IDLE -> step high exactly 1 clk, one clk after edge; held=1; rep_cnt=0.
REQ-027 Ux held 200 clk -> steps at press+1, then after 5 ticks, then every 3 ticks; rep_cnt=1 after the first repeat, rising by 1 per repeat.
REQ-028 Ux released after 3 ticks in HOLD -> no further step; held=0 next clk; rep_cnt=0.
REQ-029 Ux=1 while rst=1, then rst=0 with Ux still 1 for 100 clk -> zero steps; release then press -> one step.
REQ-030 rst pulsed mid-REPEAT -> step=0, held=0, rep_cnt=0 next clk.
REQ-031 KEY_REPEAT_ACCEL_EN defined, Ux held -> after 8th repeat, interval drops from 3 ticks to 1 tick; undefined -> stays 3 ticks.
